// File: rtl/bkg_addr_gen.sv
`default_nettype none
//============================================================================
// Module      : bkg_addr_gen
// Description : Address generator and pixel-output stage for the 20x15
//               background bitmap ROM. Converts the VGA scan position into
//               a ROM address using incremental counters only (no
//               multipliers), upscales every texel to 2^SCALE_LOG2 square
//               screen pixels, registers the returned colour index and
//               hands it, with a valid flag, to the palette/priority mux.
//
// Ports       : clk        pixel clock
//               rst        synchronous, active-high reset
//               hcnt       current horizontal pixel position (10 b)
//               vcnt       current vertical line position (10 b)
//               video_on   high in the visible area
//               rom_addr   registered ROM address (9 b), 1 clk after hcnt
//               rom_q      colour index returned combinationally by the ROM
//               pix_color  registered colour index, 2 clk after hcnt
//               pix_valid  pix_color is to be drawn this cycle
//
// Option      : `define BKG_TRANSPARENT_EN to treat colour index 0 as
//               transparent (pix_valid drops for index-0 texels). When the
//               macro is undefined every window pixel is valid.
//
// Revision    : 1.0  initial release
//============================================================================
module bkg_addr_gen #(
    parameter int X0         = 240,
    parameter int Y0         = 180,
    parameter int IMG_W      = 20,
    parameter int IMG_H      = 15,
    parameter int SCALE_LOG2 = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] hcnt,
    input  logic [9:0] vcnt,
    input  logic       video_on,
    output logic [8:0] rom_addr,
    input  logic [2:0] rom_q,
    output logic [2:0] pix_color,
    output logic       pix_valid
);

    //------------------------------------------------------------------------
    // Derived geometry, all sized to the signals they are compared with
    //------------------------------------------------------------------------
    localparam int S = 1 << SCALE_LOG2;

    localparam logic [9:0] X_LO  = 10'(X0);
    localparam logic [9:0] X_HI  = 10'(X0 + IMG_W * S);
    // Pixel counters are cleared one pixel ahead of the window so the first
    // window pixel sees col=0, xsub=0.
    localparam logic [9:0] X_CLR = 10'((X0 == 0) ? 0 : X0 - 1);
    localparam logic [9:0] Y_LO  = 10'(Y0);
    localparam logic [9:0] Y_HI  = 10'(Y0 + IMG_H * S);

    localparam logic [4:0] COL_MAX      = 5'(IMG_W - 1);
    localparam logic [8:0] ROW_STEP     = 9'(IMG_W);
    // Highest row_base ever needed (start of the last bitmap row). Holding
    // row_base here keeps row_base+col <= IMG_W*IMG_H-1 even for odd scans.
    localparam logic [8:0] ROW_BASE_MAX = 9'(IMG_W * (IMG_H - 1));

    localparam logic [SCALE_LOG2-1:0] SUB_MAX = '1;
    localparam logic [SCALE_LOG2-1:0] SUB_ONE = SCALE_LOG2'(1);

    //------------------------------------------------------------------------
    // Frame state
    //------------------------------------------------------------------------
    typedef enum logic [1:0] {
        WAIT_TOP = 2'd0,
        ROWS     = 2'd1,
        DONE     = 2'd2
    } state_t;

    state_t r_state;

    //------------------------------------------------------------------------
    // Counters and pipeline registers
    //------------------------------------------------------------------------
    logic [8:0]            r_row_base;  // IMG_W * current texel row
    logic [SCALE_LOG2-1:0] r_ysub;      // line within the current texel row
    logic [4:0]            r_col;       // current texel column
    logic [SCALE_LOG2-1:0] r_xsub;      // pixel within the current texel
    logic                  r_in_win_d;  // stage-1 window hit, feeds stage 2

    //------------------------------------------------------------------------
    // Window decode
    //------------------------------------------------------------------------
    logic       w_x_in;
    logic       w_y_in;
    logic       w_hit;
    logic [4:0] w_col;
    logic [8:0] w_addr;

    assign w_x_in = (hcnt >= X_LO) && (hcnt < X_HI);
    assign w_y_in = (vcnt >= Y_LO) && (vcnt < Y_HI);

    // Drawing is only enabled once the frame has been entered from the top;
    // this is what keeps a mid-frame reset from producing a partial image.
    assign w_hit  = w_x_in && w_y_in && video_on && (r_state == ROWS);

    // With the window touching the left screen edge the clear and the first
    // pixel coincide at hcnt==0, so the first column is forced directly.
    assign w_col  = ((X_LO == 10'd0) && (hcnt == 10'd0)) ? 5'd0 : r_col;
    assign w_addr = r_row_base + {4'd0, w_col};

    //------------------------------------------------------------------------
    // Single sequential block: frame FSM, counters, two-stage output pipe
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= WAIT_TOP;
            r_row_base <= '0;
            r_ysub     <= '0;
            r_col      <= '0;
            r_xsub     <= '0;
            r_in_win_d <= 1'b0;
            rom_addr   <= '0;
            pix_color  <= '0;
            pix_valid  <= 1'b0;
        end else begin
            //----------------------------------------------------------------
            // Frame FSM, advanced once per line at hcnt==0
            //----------------------------------------------------------------
            if (hcnt == 10'd0) begin
                case (r_state)
                    WAIT_TOP: begin
                        if (vcnt == Y_LO) begin
                            r_state    <= ROWS;
                            r_row_base <= '0;
                            r_ysub     <= '0;
                        end
                    end
                    ROWS: begin
                        // First line past the window (or any jump outside
                        // it) means the last window line has completed.
                        if ((vcnt >= Y_HI) || (vcnt < Y_LO)) begin
                            r_state <= DONE;
                        end
                    end
                    DONE: begin
                        if (vcnt == 10'd0) begin
                            r_state <= WAIT_TOP;
                        end
                    end
                    default: begin
                        r_state <= WAIT_TOP;
                    end
                endcase
            end

            //----------------------------------------------------------------
            // Line counters: step at the first pixel right of the window
            //----------------------------------------------------------------
            if ((r_state == ROWS) && (hcnt == X_HI)) begin
                r_ysub <= r_ysub + SUB_ONE;
                if ((r_ysub == SUB_MAX) && (r_row_base < ROW_BASE_MAX)) begin
                    r_row_base <= r_row_base + ROW_STEP;
                end
            end

            //----------------------------------------------------------------
            // Pixel counters: advance across the window columns regardless
            // of video_on so a blanked stretch does not shift the image.
            //----------------------------------------------------------------
            if (hcnt == X_CLR) begin
                r_col  <= '0;
                r_xsub <= (X_LO == 10'd0) ? SUB_ONE : '0;
            end else if (w_x_in) begin
                r_xsub <= r_xsub + SUB_ONE;
                if ((r_xsub == SUB_MAX) && (r_col < COL_MAX)) begin
                    r_col <= r_col + 5'd1;
                end
            end

            //----------------------------------------------------------------
            // Stage 1: ROM address (parked at 0 outside the window)
            //----------------------------------------------------------------
            rom_addr   <= w_hit ? w_addr : 9'd0;
            r_in_win_d <= w_hit;

            //----------------------------------------------------------------
            // Stage 2: register the ROM data alongside its valid flag
            //----------------------------------------------------------------
            pix_color <= r_in_win_d ? rom_q : 3'd0;
`ifdef BKG_TRANSPARENT_EN
            pix_valid <= r_in_win_d && (rom_q != 3'd0);
`else
            pix_valid <= r_in_win_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bkg_addr_gen.sv
`default_nettype none
//============================================================================
// Module      : tb_bkg_addr_gen
// Description : Self-checking bench for bkg_addr_gen. Scans frames in raster
//               order (lines outside the window are shortened to a couple of
//               cycles, window lines cover hcnt 0 and X0-2..X_END+3) and
//               compares every cycle with a position-based reference model.
// Revision    : 1.0  initial release
//============================================================================
`timescale 1ns/1ps
module tb_bkg_addr_gen;

    localparam int X0         = 240;
    localparam int Y0         = 180;
    localparam int IMG_W      = 20;
    localparam int IMG_H      = 15;
    localparam int SCALE_LOG2 = 3;
    localparam int S          = 1 << SCALE_LOG2;
    localparam int X_END      = X0 + IMG_W * S;
    localparam int Y_END      = Y0 + IMG_H * S;
    localparam int V_LAST     = Y_END + 4;
`ifdef BKG_TRANSPARENT_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] hcnt = '0;
    logic [9:0] vcnt = '0;
    logic       video_on = 1'b0;
    logic [8:0] rom_addr;
    logic [2:0] rom_q;
    logic [2:0] pix_color;
    logic       pix_valid;

    logic [2:0] rom [0:511];
    assign rom_q = rom[rom_addr];

    always #5 clk = ~clk;

    bkg_addr_gen dut (
        .clk       (clk),
        .rst       (rst),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .video_on  (video_on),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .pix_color (pix_color),
        .pix_valid (pix_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: the frame is "armed" once a line starts at Y0,
    // expected outputs derive from screen position by plain division.
    bit armed     = 1'b0;
    bit hit_d     = 1'b0;
    int addr_d    = 0;
    int exp_addr  = 0;
    int exp_color = 0;
    bit exp_valid = 1'b0;

    function automatic int line_len(input int v);
        return ((v >= Y0) && (v < Y_END)) ? 167 : 2;
    endfunction

    function automatic int h_at(input int v, input int i);
        if (i == 0) return 0;
        return ((v >= Y0) && (v < Y_END)) ? (X0 - 3 + i) : i;
    endfunction

    // Apply one cycle of inputs, advance one clock, update the model.
    task automatic drive(input int h, input int v, input bit von, input bit r);
        bit hit;
        hcnt     = 10'(h);
        vcnt     = 10'(v);
        video_on = von;
        rst      = r;
        @(posedge clk);
        #1;
        if (r) begin
            armed = 0; hit_d = 0; addr_d = 0;
            exp_addr = 0; exp_color = 0; exp_valid = 0;
        end else begin
            exp_color = hit_d ? int'(rom[addr_d]) : 0;
            exp_valid = hit_d;
            if (TRANSP && exp_color == 0) exp_valid = 1'b0;
            hit = armed && (h >= X0) && (h < X_END) && (v >= Y0) && (v < Y_END) && von;
            exp_addr = hit ? (((v - Y0) / S) * IMG_W + (h - X0) / S) : 0;
            if (h == 0 && v == Y0) armed = 1'b1;
            hit_d  = hit;
            addr_d = exp_addr;
        end
    endtask

    task automatic test_reset;
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        n_checks++;
        if (rom_addr !== 9'd0) begin
            n_fail++; $display("FAIL reset_addr: got %0d want 0", rom_addr);
        end
        n_checks++;
        if (pix_color !== 3'd0) begin
            n_fail++; $display("FAIL reset_color: got %0d want 0", pix_color);
        end
        n_checks++;
        if (pix_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %0b want 0", pix_valid);
        end
        drive(1, 0, 0, 0);
    endtask

    // Full frame, video_on held high in the window, with the fixed points.
    task automatic test_full_frame;
        int h;
        for (int v = 0; v <= V_LAST; v++) begin
            for (int i = 0; i < line_len(v); i++) begin
                h = h_at(v, i);
                drive(h, v, (v >= Y0 && v < Y_END), 0);
                n_checks++;
                if ({rom_addr, pix_color, pix_valid} !== {9'(exp_addr), 3'(exp_color), exp_valid}) begin
                    n_fail++;
                    $display("FAIL frame h=%0d v=%0d: got addr=%0d color=%0d valid=%0b, want addr=%0d color=%0d valid=%0b",
                             h, v, rom_addr, pix_color, pix_valid, exp_addr, exp_color, exp_valid);
                end
                if ((v == 180 && h == 240) || (v == 187 && h == 247)) begin
                    n_checks++;
                    if (rom_addr !== 9'd0) begin
                        n_fail++; $display("FAIL first_texel h=%0d v=%0d: got %0d want 0", h, v, rom_addr);
                    end
                end
                if (v == 180 && h == 241) begin
                    n_checks++;
                    if (pix_valid !== !TRANSP || pix_color !== 3'd0) begin
                        n_fail++; $display("FAIL index0_pixel: got valid=%0b color=%0d want valid=%0b color=0",
                                           pix_valid, pix_color, !TRANSP);
                    end
                end
                if (v == 187 && h == 248) begin
                    n_checks++;
                    if (rom_addr !== 9'd1) begin
                        n_fail++; $display("FAIL col_step: got %0d want 1", rom_addr);
                    end
                end
                if (v == 188 && h == 240) begin
                    n_checks++;
                    if (rom_addr !== 9'd20) begin
                        n_fail++; $display("FAIL row_step: got %0d want 20", rom_addr);
                    end
                end
                if (v == 212 && h == 256) begin
                    n_checks++;
                    if (rom_addr !== 9'd82) begin
                        n_fail++; $display("FAIL addr_82: got %0d want 82", rom_addr);
                    end
                end
                if (v == 212 && h == 257) begin
                    n_checks++;
                    if (pix_color !== 3'd5 || pix_valid !== 1'b1) begin
                        n_fail++; $display("FAIL color_82: got color=%0d valid=%0b want color=5 valid=1",
                                           pix_color, pix_valid);
                    end
                end
                if (v == 299 && h == 399) begin
                    n_checks++;
                    if (rom_addr !== 9'd299) begin
                        n_fail++; $display("FAIL last_addr: got %0d want 299", rom_addr);
                    end
                end
                if (v == 299 && h == 400) begin
                    n_checks++;
                    if (rom_addr !== 9'd0) begin
                        n_fail++; $display("FAIL right_edge_addr: got %0d want 0", rom_addr);
                    end
                end
                if (v == 299 && h == 401) begin
                    n_checks++;
                    if (pix_valid !== 1'b0) begin
                        n_fail++; $display("FAIL right_edge_valid: got %0b want 0", pix_valid);
                    end
                end
            end
        end
    endtask

    // Frame with video_on randomly dropped inside the window.
    task automatic test_video_on;
        int  h;
        bit  von;
        for (int v = 0; v <= V_LAST; v++) begin
            for (int i = 0; i < line_len(v); i++) begin
                h   = h_at(v, i);
                von = (v >= Y0 && v < Y_END) && ($urandom_range(0, 7) != 0);
                drive(h, v, von, 0);
                n_checks++;
                if ({rom_addr, pix_color, pix_valid} !== {9'(exp_addr), 3'(exp_color), exp_valid}) begin
                    n_fail++;
                    $display("FAIL video_on h=%0d v=%0d von=%0b: got addr=%0d color=%0d valid=%0b, want addr=%0d color=%0d valid=%0b",
                             h, v, von, rom_addr, pix_color, pix_valid, exp_addr, exp_color, exp_valid);
                end
            end
        end
    endtask

    // Reset at vcnt=200 mid-window, finish that frame, then the top rows
    // of the next frame.
    task automatic test_reset_mid_frame;
        int h;
        bit r;
        for (int f = 0; f < 2; f++) begin
            for (int v = 0; v <= ((f == 0) ? V_LAST : Y0 + 2 * S - 1); v++) begin
                for (int i = 0; i < line_len(v); i++) begin
                    h = h_at(v, i);
                    r = (f == 0) && (v == 200) && (h == 300);
                    drive(h, v, (v >= Y0 && v < Y_END), r);
                    n_checks++;
                    if ({rom_addr, pix_color, pix_valid} !== {9'(exp_addr), 3'(exp_color), exp_valid}) begin
                        n_fail++;
                        $display("FAIL reset_frame f=%0d h=%0d v=%0d: got addr=%0d color=%0d valid=%0b, want addr=%0d color=%0d valid=%0b",
                                 f, h, v, rom_addr, pix_color, pix_valid, exp_addr, exp_color, exp_valid);
                    end
                    if (r) begin
                        n_checks++;
                        if (pix_valid !== 1'b0 || rom_addr !== 9'd0) begin
                            n_fail++; $display("FAIL mid_reset_outputs: got valid=%0b addr=%0d want 0/0",
                                               pix_valid, rom_addr);
                        end
                    end
                    if (f == 1 && v == 180 && h == 241) begin
                        n_checks++;
                        if (pix_valid !== !TRANSP) begin
                            n_fail++; $display("FAIL restart_first_pixel: got %0b want %0b", pix_valid, !TRANSP);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = (i < IMG_W * IMG_H) ? 3'($urandom_range(0, 7)) : 3'd0;
        rom[0]  = 3'd0;
        rom[82] = 3'd5;

        test_reset();
        test_full_frame();
        test_video_on();
        test_reset_mid_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bkg_addr_gen.md
Name: bkg_addr_gen

Overview:
- Address generator and pixel-output stage for the 20x15 background bitmap ROM (9-bit address, 3-bit colour index).
- Takes the VGA scan position, upscales the bitmap by 2^SCALE_LOG2, and drives the ROM address.
- Registers the returned colour index and emits it, with a valid flag, to the downstream palette/priority mux.
- Uses incremental counters only; no multipliers.

Parameters:
X0, 240, left edge of the bitmap window in screen pixels
Y0, 180, top edge of the bitmap window in screen lines
IMG_W, 20, bitmap width in texels
IMG_H, 15, bitmap height in texels
SCALE_LOG2, 3, each texel is 2^SCALE_LOG2 x 2^SCALE_LOG2 screen pixels

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous, active-high reset
hcnt  in  10  current horizontal pixel position
vcnt  in  10  current vertical line position
video_on  in  1  high in the visible area
rom_addr  out  9  address to the bitmap ROM (registered)
rom_q  in  3  colour index returned combinationally by the ROM
pix_color  out  3  colour index aligned to pixel output (registered)
pix_valid  out  1  pix_color is to be drawn this cycle

Behaviour:
- S = 2^SCALE_LOG2. Window: X0 <= hcnt < X0+IMG_W*S and Y0 <= vcnt < Y0+IMG_H*S, qualified by video_on.
- Reset values: rom_addr=0, pix_color=0, pix_valid=0, all counters=0, state=WAIT_TOP.
- Frame FSM, evaluated when hcnt==0:
  - WAIT_TOP -> ROWS when vcnt==Y0.
  - ROWS -> DONE when the last window line (vcnt==Y0+IMG_H*S-1) has finished.
  - DONE -> WAIT_TOP when vcnt==0.
- Line counters:
  - row_base (9b) = IMG_W*row.
  - ysub (SCALE_LOG2 b).
  - On entry to ROWS: row_base=0, ysub=0.
  - At hcnt==X0+IMG_W*S on a ROWS line: ysub++. On ysub wrap, row_base += IMG_W.
- Pixel counters:
  - col (5b) and xsub (SCALE_LOG2 b) are cleared when hcnt==X0-1, or at hcnt==0 if X0==0.
  - Inside the window: xsub++; on xsub wrap, col++.
- Stage 1: rom_addr <= row_base+col for an in-window pixel, else 0. in_win_d <= window hit.
- Stage 2: pix_color <= in_win_d ? rom_q : 0. pix_valid <= in_win_d (subject to the optional feature).
- Latency: exactly 2 clk from hcnt/vcnt to pix_color/pix_valid. rom_addr lags by 1 clk.
- Arithmetic: rom_addr never exceeds IMG_W*IMG_H-1 = 299. col saturates at IMG_W-1 and is never used outside the window.
- Boundaries:
  - Window ends at the right edge: pix_valid drops 2 clk after hcnt==X0+IMG_W*S.
  - video_on low inside the window suppresses pix_valid and holds rom_addr=0. Counters still advance.
- Reset mid-frame: all outputs go low the cycle after rst. The FSM stays in WAIT_TOP until the next vcnt==Y0 at hcnt==0; no partial image is drawn.
- hcnt/vcnt jumps (non-monotonic input) do not need to be handled beyond never producing an address above 299.

Optional Feature:
- Macro: BKG_TRANSPARENT_EN.
- Defined: colour index 0 is transparent. pix_valid = in_win_d && (rom_q != 0), and pix_color is still registered as rom_q.
- Undefined: pix_valid = in_win_d for every window pixel, including index 0.

Test Plan:
- Reset, then scan a frame with hcnt=240, vcnt=180 -> rom_addr=0 one clk later; pix_valid=1 two clk later.
- hcnt=256, vcnt=212 (col 2, row 4) -> rom_addr=82; two clk later pix_color=5, pix_valid=1.
- hcnt=399, vcnt=299 -> rom_addr=299. The next pixel hcnt=400 -> rom_addr=0, and pix_valid=0 two clk later.
- hcnt=247 then 248 on line vcnt=187 -> addresses 0 then 1. At vcnt=188 the row_base step makes hcnt=240 give rom_addr=20.
- With BKG_TRANSPARENT_EN: hcnt=240, vcnt=180 (index 0) -> pix_valid=0. Without it -> pix_valid=1, pix_color=0.
- Assert rst at vcnt=200 mid-window -> pix_valid=0 next clk, with no output until the next frame at vcnt=180. The first line then matches the full-frame reference.
